fifo_rptr_empty_prog: RTL and testbench

- Read-side pointer and status block for the async gray-pointer FIFO; parametrised successor of the basic read-pointer/empty generator.
- Produces the binary read address, gray read pointer, registered empty flag, and exact fill level.
- Adds a programmable almost-empty threshold and a sticky underflow error flag.
- Sits in the read clock domain, between the write-pointer synchroniser and the dual-port RAM read port.

---
 rtl/fifo_rptr_empty_prog.sv | 85 ++++++++
 tb/tb_fifo_rptr_empty_prog.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_rptr_empty_prog.sv
// Read-side pointer, empty/almost-empty flags, fill level and sticky underflow.
// Optional macro FIFO_RPTR_SYNC_EN adds a two-flop wptr_in synchroniser.
module fifo_rptr_empty_prog #(
    parameter int ADDRSIZE = 4
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic                rinc,
    input  logic [ADDRSIZE:0]   wptr_in,
    input  logic [ADDRSIZE:0]   ae_thresh,
    input  logic                rerr_clr,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic                arempty,
    output logic [ADDRSIZE:0]   rlevel,
    output logic                runderflow
);

    logic [ADDRSIZE:0] rbin;
    logic [ADDRSIZE:0] rbinnext;
    logic [ADDRSIZE:0] rgraynext;
    logic [ADDRSIZE:0] wptr_s;
    logic [ADDRSIZE:0] wbin_s;
    logic [ADDRSIZE:0] levelnext;
    logic              pop;

`ifdef FIFO_RPTR_SYNC_EN
    logic [ADDRSIZE:0] wq1;
    logic [ADDRSIZE:0] wq2;

    // Two-stage capture of the raw write-domain gray pointer.
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            wq1 <= '0;
            wq2 <= '0;
        end else begin
            wq1 <= wptr_in;
            wq2 <= wq1;
        end
    end

    assign wptr_s = wq2;
`else
    assign wptr_s = wptr_in;
`endif

    // Gray to binary: bit i is the XOR of all gray bits from the MSB down to i.
    always_comb begin
        wbin_s = '0;
        for (int i = 0; i <= ADDRSIZE; i++) begin
            wbin_s[i] = ^(wptr_s >> i);
        end
    end

    // Next read pointer and the level it leaves behind.
    always_comb begin
        pop       = rinc & ~rempty;
        rbinnext  = rbin + {{ADDRSIZE{1'b0}}, pop};
        rgraynext = (rbinnext >> 1) ^ rbinnext;
        levelnext = wbin_s - rbinnext;
    end

    // Pointer, flag and level registers; underflow set beats clear.
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            rbin       <= '0;
            rptr       <= '0;
            rempty     <= 1'b1;
            arempty    <= 1'b1;
            rlevel     <= '0;
            runderflow <= 1'b0;
        end else begin
            rbin       <= rbinnext;
            rptr       <= rgraynext;
            rempty     <= (rgraynext == wptr_s);
            rlevel     <= levelnext;
            arempty    <= (levelnext <= ae_thresh);
            runderflow <= (rinc & rempty) | (runderflow & ~rerr_clr);
        end
    end

    assign raddr = rbin[ADDRSIZE-1:0];

endmodule

// File: tb/tb_fifo_rptr_empty_prog.sv
// Randomised bench for fifo_rptr_empty_prog against a counter-based model.
// Model tracks total reads/writes as integers and derives flags arithmetically.
module tb_fifo_rptr_empty_prog;

    localparam int AW = 4;
    localparam int PW = AW + 1;
    localparam int MODV = 1 << PW;
    localparam int DEPTH = 1 << AW;

    logic          rclk;
    logic          rrst_n;
    logic          rinc;
    logic [PW-1:0] wptr_in;
    logic [PW-1:0] ae_thresh;
    logic          rerr_clr;
    logic [AW-1:0] raddr;
    logic [PW-1:0] rptr;
    logic          rempty;
    logic          arempty;
    logic [PW-1:0] rlevel;
    logic          runderflow;

    fifo_rptr_empty_prog #(.ADDRSIZE(AW)) dut (
        .rclk(rclk),
        .rrst_n(rrst_n),
        .rinc(rinc),
        .wptr_in(wptr_in),
        .ae_thresh(ae_thresh),
        .rerr_clr(rerr_clr),
        .raddr(raddr),
        .rptr(rptr),
        .rempty(rempty),
        .arempty(arempty),
        .rlevel(rlevel),
        .runderflow(runderflow)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: absolute counts, not pointer encodings.
    int wr = 0;
    int m_rd = 0;
    int m_lvl = 0;
    int m_empty = 1;
    int m_ae = 1;
    int m_uf = 0;
    int ws1 = 0;
    int ws2 = 0;
    logic [PW-1:0] prev_rptr = '0;

    initial begin
        rclk = 1'b0;
        forever #5 rclk = ~rclk;
    end

    function automatic logic [PW-1:0] gray(input int b);
        logic [PW-1:0] v;
        v = PW'(b % MODV);
        return v ^ (v >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        int ws;
        int pop;
        int set_uf;
        if (!rrst_n) begin
            m_rd = 0; m_lvl = 0; m_empty = 1; m_ae = 1; m_uf = 0;
            ws1 = 0; ws2 = 0;
        end else begin
`ifdef FIFO_RPTR_SYNC_EN
            ws = ws2;
            ws2 = ws1;
            ws1 = wr % MODV;
`else
            ws = wr % MODV;
`endif
            pop = (rinc && !m_empty) ? 1 : 0;
            set_uf = (rinc && m_empty) ? 1 : 0;
            m_rd = m_rd + pop;
            m_lvl = (ws - m_rd) & (MODV - 1);
            m_empty = (m_lvl == 0) ? 1 : 0;
            m_ae = (m_lvl <= int'(ae_thresh)) ? 1 : 0;
            m_uf = (set_uf || (m_uf && !rerr_clr)) ? 1 : 0;
        end
    endtask

    task automatic step();
        wptr_in = gray(wr);
        @(posedge rclk);
        model_edge();
        #1;
        check("raddr", 32'(raddr), 32'(m_rd % DEPTH));
        check("rptr", 32'(rptr), 32'(gray(m_rd)));
        check("rempty", 32'(rempty), 32'(m_empty));
        check("arempty", 32'(arempty), 32'(m_ae));
        check("rlevel", 32'(rlevel), 32'(m_lvl));
        check("runderflow", 32'(runderflow), 32'(m_uf));
        if (rrst_n)
            check("gray_1bit", 32'($countones(rptr ^ prev_rptr) <= 1), 32'd1);
        prev_rptr = rptr;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rrst_n = 1'b0;
        rinc = 1'b1;
        wr = 2;
        ae_thresh = PW'(2);
        rerr_clr = 1'b0;

        // Reset with pop requested and a nonzero write pointer.
        settle(2);
        rrst_n = 1'b1;
        rinc = 1'b0;
        wr = 0;
        settle(3);

        // Fill to 5 then drain one at a time.
        wr = 5;
        settle(3);
        rinc = 1'b1;
        settle(5);
        rinc = 1'b0;
        settle(1);

        // Underflow set, clear, and set-beats-clear.
        rinc = 1'b1;
        settle(1);
        rinc = 1'b0;
        rerr_clr = 1'b1;
        settle(1);
        rinc = 1'b1;
        settle(1);
        rinc = 1'b0;
        rerr_clr = 1'b0;
        settle(1);
        rerr_clr = 1'b1;
        settle(1);
        rerr_clr = 1'b0;

        // Full, then 32+ pops with the writer leading to force a wrap.
        wr = m_rd + DEPTH;
        settle(3);
        rinc = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (wr + 1 - m_rd <= DEPTH && $urandom_range(0, 3) != 0) wr++;
            step();
        end
        rinc = 1'b0;

        // Level 3, then write and pop together.
        wr = m_rd + 3;
        settle(3);
        rinc = 1'b1;
        wr++;
        settle(1);
        rinc = 1'b0;
        settle(3);

        // Random traffic, thresholds, clears and occasional resets.
        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 0) ae_thresh = PW'($urandom_range(0, MODV - 1));
            rinc = 1'($urandom_range(0, 1));
            rerr_clr = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 1) == 1 && wr + 1 - m_rd <= DEPTH) wr++;
            if ($urandom_range(0, 149) == 0) begin
                rrst_n = 1'b0;
                step();
                rrst_n = 1'b1;
                wr = $urandom_range(0, DEPTH);
            end else begin
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
